// File: rtl/riscv_csr_ctrl_pkg.sv
// Shared definitions for the machine CSR access sequencer.
//   CSR_FUN          : CSR instruction function (write / set / clear)
//   CSR_ADDR_*       : addresses of the trap-handling CSRs
//   csr_ctrl_state_t : sequencer FSM states
package riscv_constants;

    // CSR_NONE is a reserved encoding; it is not a legal CSR function.
    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_W    = 2'b01,
        CSR_S    = 2'b10,
        CSR_C    = 2'b11
    } CSR_FUN;

    localparam logic [11:0] CSR_ADDR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_ADDR_MTVEC  = 12'h305;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        WB      = 3'd2,
        T_EPC   = 3'd3,
        T_CAUSE = 3'd4,
        T_VEC   = 3'd5,
        M_RD    = 3'd6,
        M_OUT   = 3'd7
    } csr_ctrl_state_t;

endpackage

// File: rtl/riscv_csr_ctrl_alu.sv
// Modify step of a CSR read-modify-write.
//   reg_data : rs1 value or zero-extended uimm
//   csr_data : current CSR value
//   fun      : CSR_W / CSR_S / CSR_C
//   alu_out  : new CSR value
module riscv_csr_alu
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic [WORD_LENGTH-1:0] reg_data,
    input  logic [WORD_LENGTH-1:0] csr_data,
    input  CSR_FUN                 fun,
    output logic [WORD_LENGTH-1:0] alu_out
);

    always_comb begin
        alu_out = csr_data;
        case (fun)
            CSR_W:   alu_out = reg_data;
            CSR_S:   alu_out = csr_data | reg_data;
            CSR_C:   alu_out = csr_data & ~reg_data;
            default: alu_out = csr_data;
        endcase
    end

endmodule

// File: rtl/riscv_csr_ctrl.sv
// Machine CSR access sequencer. Owns the single CSR read and write ports and
// arbitrates trap entry > mret > CSR instruction.
//   req_*      : CSR instruction handshake and operands
//   rsp_*      : one-cycle response (old CSR value / illegal flag)
//   trap_*     : trap entry handshake, cause and faulting PC
//   mret_*     : mret handshake
//   redirect_* : one-cycle fetch redirect
//   csr_r*     : CSR file read port (data returns the cycle after csr_re)
//   csr_w*     : CSR file write port
module riscv_csr_ctrl
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  CSR_FUN                 req_fun,
    input  logic [11:0]            req_addr,
    input  logic [WORD_LENGTH-1:0] req_src,
    input  logic                   req_src_zero,
    output logic                   rsp_valid,
    output logic [WORD_LENGTH-1:0] rsp_rdata,
    output logic                   rsp_illegal,
    input  logic                   trap_valid,
    output logic                   trap_ready,
    input  logic [WORD_LENGTH-1:0] trap_cause,
    input  logic [WORD_LENGTH-1:0] trap_pc,
    input  logic                   mret_valid,
    output logic                   mret_ready,
    output logic                   redirect_valid,
    output logic [WORD_LENGTH-1:0] redirect_pc,
    output logic                   csr_re,
    output logic [11:0]            csr_raddr,
    input  logic [WORD_LENGTH-1:0] csr_rdata,
    input  logic                   csr_rhit,
    output logic                   csr_we,
    output logic [11:0]            csr_waddr,
    output logic [WORD_LENGTH-1:0] csr_wdata
);

    localparam logic [WORD_LENGTH-1:0] PC_ALIGN = ~{{(WORD_LENGTH-2){1'b0}}, 2'b11};

    csr_ctrl_state_t        state_q, state_d;
    CSR_FUN                 fun_q, fun_d;
    logic [11:0]            addr_q, addr_d;
    logic [WORD_LENGTH-1:0] src_q, src_d;
    logic                   src_zero_q, src_zero_d;
    logic [WORD_LENGTH-1:0] epc_q, epc_d;
    logic [WORD_LENGTH-1:0] cause_q, cause_d;

    logic [WORD_LENGTH-1:0] alu_out;
    logic                   wr;
    logic                   fun_ok;
    logic                   illegal;

    riscv_csr_alu #(.WORD_LENGTH(WORD_LENGTH)) u_alu (
        .reg_data (src_q),
        .csr_data (csr_rdata),
        .fun      (fun_q),
        .alu_out  (alu_out)
    );

    // Write decision: CSRS/CSRC with a zero source never write, so they may
    // legally read a read-only CSR.
    always_comb begin
        fun_ok  = (fun_q == CSR_W) || (fun_q == CSR_S) || (fun_q == CSR_C);
        wr      = (fun_q == CSR_W) | ~src_zero_q;
        illegal = ~csr_rhit | (wr & (addr_q[11:10] == 2'b11)) | ~fun_ok;
    end

    always_comb begin
        state_d    = state_q;
        fun_d      = fun_q;
        addr_d     = addr_q;
        src_d      = src_q;
        src_zero_d = src_zero_q;
        epc_d      = epc_q;
        cause_d    = cause_q;

        req_ready      = 1'b0;
        trap_ready     = 1'b0;
        mret_ready     = 1'b0;
        rsp_valid      = 1'b0;
        rsp_rdata      = '0;
        rsp_illegal    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        csr_re         = 1'b0;
        csr_raddr      = '0;
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;

        case (state_q)
            IDLE: begin
                // Only the highest-priority pending source sees ready.
                if (trap_valid) begin
                    trap_ready = 1'b1;
                    epc_d      = trap_pc;
                    cause_d    = trap_cause;
                    state_d    = T_EPC;
                end else if (mret_valid) begin
                    mret_ready = 1'b1;
                    state_d    = M_RD;
                end else if (req_valid) begin
                    req_ready  = 1'b1;
                    fun_d      = req_fun;
                    addr_d     = req_addr;
                    src_d      = req_src;
                    src_zero_d = req_src_zero;
                    state_d    = RD;
                end
            end
            RD: begin
                csr_re    = 1'b1;
                csr_raddr = addr_q;
                state_d   = WB;
            end
            WB: begin
                rsp_valid   = 1'b1;
                rsp_illegal = illegal;
                rsp_rdata   = illegal ? '0 : csr_rdata;
                csr_we      = wr & ~illegal;
                csr_waddr   = (wr & ~illegal) ? addr_q : 12'h000;
                csr_wdata   = (wr & ~illegal) ? alu_out : '0;
                state_d     = IDLE;
            end
            T_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_ADDR_MEPC;
                csr_wdata = epc_q & PC_ALIGN;
                state_d   = T_CAUSE;
            end
            T_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_ADDR_MCAUSE;
                csr_wdata = cause_q;
                csr_re    = 1'b1;
                csr_raddr = CSR_ADDR_MTVEC;
                state_d   = T_VEC;
            end
            T_VEC: begin
                // Direct mode only: the mode bits are simply masked off.
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata & PC_ALIGN;
                state_d        = IDLE;
            end
            M_RD: begin
                csr_re    = 1'b1;
                csr_raddr = CSR_ADDR_MEPC;
                state_d   = M_OUT;
            end
            M_OUT: begin
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latches are only consumed in states entered after a load.
    always_ff @(posedge clk) begin
        fun_q      <= fun_d;
        addr_q     <= addr_d;
        src_q      <= src_d;
        src_zero_q <= src_zero_d;
        epc_q      <= epc_d;
        cause_q    <= cause_d;
    end

endmodule

// File: tb/tb_riscv_csr_ctrl.sv
module tb_riscv_csr_ctrl;
    import riscv_constants::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    CSR_FUN      req_fun;
    logic [11:0] req_addr;
    logic [31:0] req_src;
    logic        req_src_zero;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;
    logic        trap_valid;
    logic        trap_ready;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret_valid;
    logic        mret_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        csr_re;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_rhit;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;

    int tests = 0;
    int fails = 0;

    riscv_csr_ctrl #(.WORD_LENGTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_fun(req_fun),
        .req_addr(req_addr), .req_src(req_src), .req_src_zero(req_src_zero),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
        .trap_valid(trap_valid), .trap_ready(trap_ready),
        .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret_valid(mret_valid), .mret_ready(mret_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_re(csr_re), .csr_raddr(csr_raddr),
        .csr_rdata(csr_rdata), .csr_rhit(csr_rhit),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request in IDLE, check it is accepted, and advance into WB.
    task automatic req_to_wb(input string tag, input CSR_FUN f, input logic [11:0] a,
                             input logic [31:0] s, input logic z,
                             input logic [31:0] rd, input logic hit);
        req_valid = 1'b1; req_fun = f; req_addr = a; req_src = s; req_src_zero = z;
        #1;
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk({tag, "_rd_re"}, {31'b0, csr_re}, 32'd1);
        chk({tag, "_rd_addr"}, {20'b0, csr_raddr}, {20'b0, a});
        chk({tag, "_rd_norsp"}, {31'b0, rsp_valid}, 32'd0);
        csr_rdata = rd; csr_rhit = hit;
        tick();
        chk({tag, "_wb_vld"}, {31'b0, rsp_valid}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_fun = CSR_W; req_addr = '0; req_src = '0; req_src_zero = 1'b0;
        trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; mret_valid = 1'b0;
        csr_rdata = '0; csr_rhit = 1'b1;
        repeat (2) tick();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_csr_we", {31'b0, csr_we}, 32'd0);
        chk("rst_csr_re", {31'b0, csr_re}, 32'd0);
        chk("rst_redirect", {31'b0, redirect_valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // CSRS 0x300, src 0x0F, old 0xF0
        req_to_wb("t1", CSR_S, 12'h300, 32'h0F, 1'b0, 32'h0000_00F0, 1'b1);
        chk("t1_rdata", rsp_rdata, 32'hF0);
        chk("t1_ill", {31'b0, rsp_illegal}, 32'd0);
        chk("t1_we", {31'b0, csr_we}, 32'd1);
        chk("t1_waddr", {20'b0, csr_waddr}, 32'h300);
        chk("t1_wdata", csr_wdata, 32'hFF);
        tick();
        chk("t1_idle_vld", {31'b0, rsp_valid}, 32'd0);
        chk("t1_idle_we", {31'b0, csr_we}, 32'd0);

        // CSRC with zero source: read only
        req_to_wb("t2", CSR_C, 12'h300, 32'h0, 1'b1, 32'hFF, 1'b1);
        chk("t2_rdata", rsp_rdata, 32'hFF);
        chk("t2_we", {31'b0, csr_we}, 32'd0);
        chk("t2_ill", {31'b0, rsp_illegal}, 32'd0);
        tick();

        // CSRW to read-only CSR
        req_to_wb("t3a", CSR_W, 12'hF14, 32'h5, 1'b0, 32'h1234, 1'b1);
        chk("t3a_ill", {31'b0, rsp_illegal}, 32'd1);
        chk("t3a_we", {31'b0, csr_we}, 32'd0);
        chk("t3a_rdata", rsp_rdata, 32'h0);
        tick();
        // CSRS with zero source on read-only CSR is legal
        req_to_wb("t3b", CSR_S, 12'hF14, 32'h0, 1'b1, 32'hABCD, 1'b1);
        chk("t3b_ill", {31'b0, rsp_illegal}, 32'd0);
        chk("t3b_rdata", rsp_rdata, 32'hABCD);
        chk("t3b_we", {31'b0, csr_we}, 32'd0);
        tick();
        // Unimplemented CSR
        req_to_wb("t3c", CSR_S, 12'h7C0, 32'h1, 1'b0, 32'h55, 1'b0);
        chk("t3c_ill", {31'b0, rsp_illegal}, 32'd1);
        chk("t3c_we", {31'b0, csr_we}, 32'd0);
        tick();
        // Invalid function encoding
        req_to_wb("t3d", CSR_NONE, 12'h300, 32'h1, 1'b0, 32'h55, 1'b1);
        chk("t3d_ill", {31'b0, rsp_illegal}, 32'd1);
        chk("t3d_we", {31'b0, csr_we}, 32'd0);
        tick();
        // CSRC with mask and CSRW data path
        req_to_wb("t3e", CSR_C, 12'h300, 32'h0F, 1'b0, 32'hFF, 1'b1);
        chk("t3e_wdata", csr_wdata, 32'hF0);
        chk("t3e_we", {31'b0, csr_we}, 32'd1);
        tick();
        req_to_wb("t3f", CSR_W, 12'h340, 32'hDEAD_BEEF, 1'b0, 32'h1, 1'b1);
        chk("t3f_wdata", csr_wdata, 32'hDEAD_BEEF);
        chk("t3f_waddr", {20'b0, csr_waddr}, 32'h340);
        chk("t3f_rdata", rsp_rdata, 32'h1);
        tick();

        // Trap and request together: trap wins, request waits
        trap_valid = 1'b1; trap_pc = 32'h8000_0102; trap_cause = 32'h2;
        req_valid = 1'b1; req_fun = CSR_S; req_addr = 12'h300; req_src = 32'h0; req_src_zero = 1'b1;
        #1;
        chk("t4_trap_ready", {31'b0, trap_ready}, 32'd1);
        chk("t4_req_ready", {31'b0, req_ready}, 32'd0);
        chk("t4_mret_ready", {31'b0, mret_ready}, 32'd0);
        tick();
        trap_valid = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0;
        chk("t4_epc_we", {31'b0, csr_we}, 32'd1);
        chk("t4_epc_addr", {20'b0, csr_waddr}, 32'h341);
        chk("t4_epc_data", csr_wdata, 32'h8000_0100);
        chk("t4_busy_ready", {31'b0, req_ready}, 32'd0);
        tick();
        chk("t4_cause_we", {31'b0, csr_we}, 32'd1);
        chk("t4_cause_addr", {20'b0, csr_waddr}, 32'h342);
        chk("t4_cause_data", csr_wdata, 32'h2);
        chk("t4_vec_re", {31'b0, csr_re}, 32'd1);
        chk("t4_vec_raddr", {20'b0, csr_raddr}, 32'h305);
        csr_rdata = 32'h8000_0041;
        tick();
        chk("t4_redir_vld", {31'b0, redirect_valid}, 32'd1);
        chk("t4_redir_pc", redirect_pc, 32'h8000_0040);
        chk("t4_vec_nowe", {31'b0, csr_we}, 32'd0);
        tick();
        chk("t4_redir_done", {31'b0, redirect_valid}, 32'd0);
        chk("t4_req_accept", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk("t4_req_rd", {20'b0, csr_raddr}, 32'h300);
        csr_rdata = 32'h77;
        tick();
        chk("t4_req_rsp", {31'b0, rsp_valid}, 32'd1);
        chk("t4_req_rdata", rsp_rdata, 32'h77);
        tick();

        // mret beats a concurrent request
        mret_valid = 1'b1; req_valid = 1'b1; req_fun = CSR_W; req_addr = 12'h300; req_src_zero = 1'b0;
        #1;
        chk("t5_mret_ready", {31'b0, mret_ready}, 32'd1);
        chk("t5_req_ready", {31'b0, req_ready}, 32'd0);
        tick();
        mret_valid = 1'b0; req_valid = 1'b0;
        chk("t5_re", {31'b0, csr_re}, 32'd1);
        chk("t5_raddr", {20'b0, csr_raddr}, 32'h341);
        chk("t5_noredir", {31'b0, redirect_valid}, 32'd0);
        csr_rdata = 32'h8000_0100;
        tick();
        chk("t5_redir_vld", {31'b0, redirect_valid}, 32'd1);
        chk("t5_redir_pc", redirect_pc, 32'h8000_0100);
        tick();
        chk("t5_redir_done", {31'b0, redirect_valid}, 32'd0);

        // Reset during RD of a CSRW
        req_valid = 1'b1; req_fun = CSR_W; req_addr = 12'h300; req_src = 32'h1111; req_src_zero = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("t6_in_rd", {31'b0, csr_re}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_re", {31'b0, csr_re}, 32'd0);
        tick();
        chk("t6_rst_we", {31'b0, csr_we}, 32'd0);
        chk("t6_rst_rsp", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t6_post_we", {31'b0, csr_we}, 32'd0);
        chk("t6_post_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("t6_post_re", {31'b0, csr_re}, 32'd0);
        chk("t6_post_redir", {31'b0, redirect_valid}, 32'd0);
        chk("t6_post_ready", {29'b0, req_ready, trap_ready, mret_ready}, 32'd0);
        // FSM is back in IDLE: a new request is accepted at once
        req_valid = 1'b1; req_fun = CSR_S; req_src_zero = 1'b1;
        #1;
        chk("t6_idle_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_csr_ctrl.md
Name: riscv_csr_ctrl

Overview:
Sequences every access to the machine CSR file: CSR instructions do a read-modify-write, trap entry saves mepc and mcause then fetches mtvec, and mret fetches mepc. The block sits between the execute stage and the CSR storage array and owns the single CSR read port and the single CSR write port. It instantiates riscv_csr_alu for the modify step, and it arbitrates between trap, mret and instruction requests.

Parameters:
WORD_LENGTH, 32, width of CSR data, PCs and cause.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  CSR instruction request
req_ready  out  1  request accepted when valid&ready
req_fun  in  CSR_FUN  CSR_W / CSR_S / CSR_C
req_addr  in  12  CSR address
req_src  in  WORD_LENGTH  rs1 value or zero-extended uimm
req_src_zero  in  1  rs1==x0 (or uimm==0)
rsp_valid  out  1  one-cycle pulse; response for accepted request
rsp_rdata  out  WORD_LENGTH  old CSR value (written to rd)
rsp_illegal  out  1  qualifies rsp_valid: illegal-instruction
trap_valid  in  1  trap entry request
trap_ready  out  1  trap accepted
trap_cause  in  WORD_LENGTH  mcause value
trap_pc  in  WORD_LENGTH  faulting PC
mret_valid  in  1  mret request
mret_ready  out  1  mret accepted
redirect_valid  out  1  one-cycle pulse; fetch redirect
redirect_pc  out  WORD_LENGTH  redirect target
csr_re  out  1  CSR file read enable
csr_raddr  out  12  read address
csr_rdata  in  WORD_LENGTH  read data, valid the cycle after csr_re
csr_rhit  in  1  address implemented, valid with csr_rdata
csr_we  out  1  CSR file write enable
csr_waddr  out  12  write address
csr_wdata  out  WORD_LENGTH  write data

Behaviour:
- The clock is clk. rst_n is asynchronous and active-low. Reset drives the FSM to IDLE and clears every output, including the ready signals, to 0.
- FSM states: IDLE, RD, WB, T_EPC, T_CAUSE, T_VEC, M_RD, M_OUT.
- The ready signals are asserted only in IDLE, and only one of them at a time.
- Priority in IDLE is trap > mret > req. A request that is not selected sees ready=0 and must hold its valid.
- Request path, from acceptance edge t:
  - RD: csr_re=1, csr_raddr=latched addr.
  - WB: alu_out = riscv_csr_alu(reg_data=latched src, csr_data=csr_rdata, latched fun). rsp_valid=1 and rsp_rdata=csr_rdata. Return to IDLE.
  - Latency: rsp_valid arrives 2 cycles after acceptance. Throughput is 1 request per 3 cycles.
- Write decision in WB:
  - wr = (fun==CSR_W) | ~src_zero.
  - illegal = ~csr_rhit | (wr & addr[11:10]==2'b11) | fun not in {W,S,C}.
  - csr_we = wr & ~illegal, with csr_waddr=addr and csr_wdata=alu_out.
  - When illegal: rsp_illegal=1, rsp_rdata=0, and no write occurs.
- Trap path:
  - T_EPC: csr_we with mepc := {trap_pc[W-1:2],2'b00}.
  - T_CAUSE: csr_we with mcause := trap_cause. In the same cycle csr_re is asserted on mtvec.
  - T_VEC: redirect_valid=1, redirect_pc={csr_rdata[W-1:2],2'b00} (direct mode only). Return to IDLE.
  - Trap inputs are latched at acceptance.
- Mret path:
  - M_RD: csr_re on mepc.
  - M_OUT: redirect_valid=1, redirect_pc=csr_rdata. Return to IDLE.
- Simultaneous read and write in the same cycle target different addresses. The CSR file is write-first only for the same address, which the FSM never generates.
- Inputs arriving while busy are ignored until IDLE. A trap_valid raised during a request completes after that request.
- Reset mid-sequence aborts the operation and suppresses any pending write or response. The CSR file contents are not rolled back.
- All arithmetic is WORD_LENGTH wide. No sign extension is performed here.

Decomposition:
- Package riscv_constants:
  - CSR_FUN enum, already present.
  - localparams CSR_ADDR_MEPC=12'h341, CSR_ADDR_MCAUSE=12'h342, CSR_ADDR_MTVEC=12'h305.
  - csr_ctrl_state_t enum for the FSM states.
- Sub-module: riscv_csr_alu, instantiated once. No other sub-module.

Test Plan:
1. csr_rdata=32'h0000_00F0, req CSR_S addr 12'h300 src 32'h0F, src_zero=0 -> WB: rsp_rdata=32'hF0, csr_we=1, csr_wdata=32'hFF, rsp_valid exactly 2 cycles after accept.
2. req CSR_C addr 12'h300 src_zero=1 (rdata 32'hFF) -> rsp_rdata=32'hFF, csr_we=0, rsp_illegal=0.
3. req CSR_W addr 12'hF14 (read-only) -> rsp_illegal=1, csr_we=0. The same address with CSR_S and src_zero=1 -> legal, rsp_rdata=rdata.
4. trap_valid and req_valid asserted together, trap_pc=32'h8000_0102, cause=32'h2, mtvec=32'h8000_0041 -> trap_ready first; mepc write 32'h8000_0100, mcause write 2, redirect_pc=32'h8000_0040; req accepted in the following IDLE.
5. mret_valid with mepc=32'h8000_0100 -> csr_re on 12'h341, redirect_valid pulse with 32'h8000_0100 two cycles after accept.
6. rst_n low in the RD cycle of a CSR_W -> no csr_we, no rsp_valid; after release FSM is in IDLE with all outputs 0.
